// File: rtl/counter_updown_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_updown_mod                                                         |
// | Parametrised modulo-N up/down counter: load, wrap/saturate, sticky ovf,    |
// | cascadable carry. Define COUNTER_MATCH_EN to add the cmp/match comparator. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module counter_updown_mod #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cin,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
`ifdef COUNTER_MATCH_EN
  input  logic [WIDTH-1:0] cmp,
  output logic             match,
`endif
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf
);

  // One extra bit lets MODULUS = 2^WIDTH be represented without a special case.
  localparam logic [WIDTH:0] c_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] c_MAX = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_d_clamped;
  logic             w_ovf_next;
  logic             w_term;
  logic             w_at_top;
  logic             w_at_zero;

  assign w_at_top    = ({1'b0, r_q} == c_MAX);
  assign w_at_zero   = (r_q == '0);
  assign w_d_clamped = ({1'b0, d} < c_MOD) ? d : c_MAX[WIDTH-1:0];

  always_comb begin
    w_q_next = r_q;
    w_term   = 1'b0;
    if (load) begin
      w_q_next = w_d_clamped;
    end else if (cin) begin
      if (up) begin
        if (w_at_top) begin
          w_term   = 1'b1;
          w_q_next = (SATURATE != 0) ? r_q : '0;
        end else begin
          w_q_next = WIDTH'({1'b0, r_q} + 1'b1);
        end
      end else begin
        if (w_at_zero) begin
          w_term   = 1'b1;
          w_q_next = (SATURATE != 0) ? '0 : c_MAX[WIDTH-1:0];
        end else begin
          w_q_next = r_q - 1'b1;
        end
      end
    end
  end

  // A terminal crossing outranks a simultaneous clr_ovf.
  always_comb begin
    w_ovf_next = r_ovf;
    if (load) begin
      w_ovf_next = 1'b0;
    end else if (w_term) begin
      w_ovf_next = 1'b1;
    end else if (clr_ovf) begin
      w_ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_ovf <= w_ovf_next;
    end
  end

`ifdef COUNTER_MATCH_EN
  logic r_match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match <= 1'b0;
    end else begin
      r_match <= (load | cin) & (w_q_next == cmp);
    end
  end

  assign match = r_match;
`endif

  assign q    = r_q;
  assign ovf  = r_ovf;
  assign cout = cin & ~load & (up ? w_at_top : w_at_zero);

endmodule
`default_nettype wire
